// File: rtl/uart_program_loader.sv
// -----------------------------------------------------------------------------
// uart_program_loader
//
// Boot loader between a UART receiver and the instruction memory / core start
// logic. It receives a 4-byte little-endian byte count N and then N program
// bytes. The bytes are packed into 32-bit little-endian words and written to
// instruction memory from word address 0. After the last write the core is
// released (o_cpu_start), and every later UART byte goes to the core through a
// one-stage registered passthrough.
//
// Optional feature (macro LOADER_ACK_EN): adds a one-byte acknowledge on a
// valid/ready transmit port. 0xAA is sent on entry to RUN and 0xEE on entry to
// ERR, once per load.
//
// Parameters:
//   IMEM_ADDR_W  instruction-memory word-address width (2^IMEM_ADDR_W words)
//   LEN_W        width of the length field and remaining-byte counter
//
// Ports:
//   i_clk           system clock
//   i_rst           asynchronous, active-high reset
//   i_rx_data       byte from UART receiver
//   i_rx_valid      one-cycle strobe, i_rx_data valid
//   o_imem_we       instruction-memory write enable (one cycle per word)
//   o_imem_addr     word address for the write
//   o_imem_wdata    word data for the write
//   o_cpu_start     level, core released from hold when high
//   o_cpu_rx_data   runtime byte to core
//   o_cpu_rx_valid  one-cycle strobe for o_cpu_rx_data
//   o_load_err      sticky, declared length exceeds memory capacity
//   o_busy          high while receiving the length or the program
//   o_tx_data       (LOADER_ACK_EN) acknowledge byte
//   o_tx_valid      (LOADER_ACK_EN) acknowledge valid, held until i_tx_ready
//   i_tx_ready      (LOADER_ACK_EN) acknowledge accepted by the transmitter
//
// state  | meaning
// S_LEN  | collecting the 4 length bytes, LSB first
// S_DATA | packing program bytes into words and writing them
// S_RUN  | core released, bytes forwarded to the core
// S_ERR  | length too large, bytes ignored until reset
// -----------------------------------------------------------------------------
module uart_program_loader #(
  parameter int IMEM_ADDR_W = 12,
  parameter int LEN_W       = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic                   o_imem_we,
  output logic [IMEM_ADDR_W-1:0] o_imem_addr,
  output logic [31:0]            o_imem_wdata,
  output logic                   o_cpu_start,
  output logic [7:0]             o_cpu_rx_data,
  output logic                   o_cpu_rx_valid,
  output logic                   o_load_err,
  output logic                   o_busy
`ifdef LOADER_ACK_EN
  ,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready
`endif
);

  typedef enum logic [1:0] {S_LEN, S_DATA, S_RUN, S_ERR} state_t;

  // Capacity in bytes, one bit wider than the length so the compare cannot wrap.
  localparam logic [32:0] CAP_BYTES = 33'(4) << IMEM_ADDR_W;

  state_t                 r_state;
  state_t                 w_state_next;

  logic [23:0]            r_len_sh;
  logic [1:0]             r_len_idx;
  logic [LEN_W-1:0]       r_remaining;
  logic [1:0]             r_lane;
  logic [31:0]            r_buf;
  logic [IMEM_ADDR_W-1:0] r_word_addr;

  logic                   r_imem_we;
  logic [IMEM_ADDR_W-1:0] r_imem_addr;
  logic [31:0]            r_imem_wdata;
  logic                   r_cpu_start;
  logic [7:0]             r_cpu_rx_data;
  logic                   r_cpu_rx_valid;

  logic [31:0]            w_len;
  logic                   w_len_last;
  logic                   w_len_zero;
  logic                   w_len_over;
  logic                   w_data_byte;
  logic                   w_last_byte;
  logic                   w_word_done;
  logic [31:0]            w_buf_merged;

  // The 4th length byte is combined with the three already shifted in, so the
  // decision is taken in the same cycle the byte arrives.
  assign w_len       = {i_rx_data, r_len_sh};
  assign w_len_last  = (r_state == S_LEN) && i_rx_valid && (r_len_idx == 2'd3);
  assign w_len_zero  = (w_len == 32'd0);
  assign w_len_over  = ({1'b0, w_len} > CAP_BYTES);
  assign w_data_byte = (r_state == S_DATA) && i_rx_valid;
  assign w_last_byte = (r_remaining == LEN_W'(1));
  assign w_word_done = w_data_byte && ((r_lane == 2'd3) || w_last_byte);

  always_comb begin
    w_buf_merged = r_buf;
    w_buf_merged[{r_lane, 3'b000} +: 8] = i_rx_data;
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_LEN;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LEN: begin
        if (w_len_last) begin
          if (w_len_zero)      w_state_next = S_RUN;
          else if (w_len_over) w_state_next = S_ERR;
          else                 w_state_next = S_DATA;
        end
      end
      S_DATA:  if (w_data_byte && w_last_byte) w_state_next = S_RUN;
      S_RUN:   w_state_next = S_RUN;
      S_ERR:   w_state_next = S_ERR;
      default: w_state_next = S_LEN;
    endcase
  end

  // Output logic; busy is held low while reset is asserted so that every
  // output reads 0 during reset.
  always_comb begin
    o_busy     = 1'b0;
    o_load_err = 1'b0;
    case (r_state)
      S_LEN, S_DATA: o_busy = ~i_rst;
      S_ERR:         o_load_err = 1'b1;
      default:       ;
    endcase
  end

  // Datapath: length capture, word packing, memory write, runtime passthrough
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_len_sh       <= '0;
      r_len_idx      <= '0;
      r_remaining    <= '0;
      r_lane         <= '0;
      r_buf          <= '0;
      r_word_addr    <= '0;
      r_imem_we      <= 1'b0;
      r_imem_addr    <= '0;
      r_imem_wdata   <= '0;
      r_cpu_start    <= 1'b0;
      r_cpu_rx_data  <= '0;
      r_cpu_rx_valid <= 1'b0;
    end else begin
      r_imem_we      <= 1'b0;
      r_cpu_rx_valid <= 1'b0;
      // Registered from the state so it rises the cycle after RUN is entered,
      // never alongside the final memory write.
      r_cpu_start    <= (r_state == S_RUN);

      if ((r_state == S_LEN) && i_rx_valid) begin
        r_len_sh  <= {i_rx_data, r_len_sh[23:8]};
        r_len_idx <= r_len_idx + 2'd1;
        if (r_len_idx == 2'd3) r_remaining <= LEN_W'(w_len);
      end

      if (w_data_byte) begin
        r_remaining <= r_remaining - LEN_W'(1);
        if (w_word_done) begin
          r_imem_we    <= 1'b1;
          r_imem_wdata <= w_buf_merged;
          r_imem_addr  <= r_word_addr;
          r_word_addr  <= r_word_addr + 1'b1;
          r_buf        <= '0;
          r_lane       <= '0;
        end else begin
          r_buf  <= w_buf_merged;
          r_lane <= r_lane + 2'd1;
        end
      end

      if ((r_state == S_RUN) && i_rx_valid) begin
        r_cpu_rx_valid <= 1'b1;
        r_cpu_rx_data  <= i_rx_data;
      end
    end
  end

  assign o_imem_we      = r_imem_we;
  assign o_imem_addr    = r_imem_addr;
  assign o_imem_wdata   = r_imem_wdata;
  assign o_cpu_start    = r_cpu_start;
  assign o_cpu_rx_data  = r_cpu_rx_data;
  assign o_cpu_rx_valid = r_cpu_rx_valid;

`ifdef LOADER_ACK_EN
  logic [7:0] r_tx_data;
  logic       r_tx_valid;
  logic       w_enter_done;

  // RUN and ERR are each entered at most once per load, giving one ack.
  assign w_enter_done = (r_state != w_state_next) &&
                        ((w_state_next == S_RUN) || (w_state_next == S_ERR));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else if (w_enter_done) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= (w_state_next == S_RUN) ? 8'hAA : 8'hEE;
    end else if (r_tx_valid && i_tx_ready) begin
      r_tx_valid <= 1'b0;
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
`endif

endmodule

// File: tb/tb_uart_program_loader.sv
module tb_uart_program_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        imem_we;
  logic [11:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_start;
  logic [7:0]  cpu_rx_data;
  logic        cpu_rx_valid;
  logic        load_err;
  logic        busy;
`ifdef LOADER_ACK_EN
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
`endif

  int checks = 0;
  int errors = 0;

  uart_program_loader #(.IMEM_ADDR_W(12), .LEN_W(32)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_rx_data      (rx_data),
    .i_rx_valid     (rx_valid),
    .o_imem_we      (imem_we),
    .o_imem_addr    (imem_addr),
    .o_imem_wdata   (imem_wdata),
    .o_cpu_start    (cpu_start),
    .o_cpu_rx_data  (cpu_rx_data),
    .o_cpu_rx_valid (cpu_rx_valid),
    .o_load_err     (load_err),
    .o_busy         (busy)
`ifdef LOADER_ACK_EN
    ,
    .o_tx_data      (tx_data),
    .o_tx_valid     (tx_valid),
    .i_tx_ready     (tx_ready)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // posedge counter; outputs registered at posedge k are recorded with pcyc=k
  int pcyc = 0;
  always @(posedge clk) pcyc = pcyc + 1;

  // Monitor: records memory writes, passthrough bytes and the cpu_start rise
  logic [31:0] wr_data [0:63];
  logic [11:0] wr_addr [0:63];
  int          wr_pcyc [0:63];
  int          wr_cnt = 0;
  logic [7:0]  rxd [0:15];
  int          rx_pcyc [0:15];
  int          rx_cnt = 0;
  int          start_pcyc = -1;
  bit          overlap = 1'b0;

  always @(negedge clk) begin
    if (imem_we) begin
      if (wr_cnt < 64) begin
        wr_data[wr_cnt] = imem_wdata;
        wr_addr[wr_cnt] = imem_addr;
        wr_pcyc[wr_cnt] = pcyc;
      end
      wr_cnt = wr_cnt + 1;
    end
    if (cpu_rx_valid) begin
      if (rx_cnt < 16) begin
        rxd[rx_cnt]     = cpu_rx_data;
        rx_pcyc[rx_cnt] = pcyc;
      end
      rx_cnt = rx_cnt + 1;
    end
    if (cpu_start && start_pcyc < 0) start_pcyc = pcyc;
    if (cpu_start && imem_we) overlap = 1'b1;
  end

  int last_pcyc;

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid  = 1'b0;
    last_pcyc = pcyc;
  endtask

  task automatic send_len(input logic [31:0] n);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_cnt     = 0;
    rx_cnt     = 0;
    start_pcyc = -1;
    overlap    = 1'b0;
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    idle(2);
    clear_mon();
    @(negedge clk);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
`ifdef LOADER_ACK_EN
    tx_ready = 1'b0;
`endif
    idle(3);
    checks++;
    if ({imem_we, cpu_start, cpu_rx_valid, load_err, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got we/start/rxv/err/busy=%b expected 00000",
               {imem_we, cpu_start, cpu_rx_valid, load_err, busy});
    end
    checks++;
    if ({imem_addr, imem_wdata, cpu_rx_data} !== 52'd0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h rxd=%h expected all 0",
               imem_addr, imem_wdata, cpu_rx_data);
    end
    clear_mon();
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy_len: got %b expected 1", busy);
    end
  endtask

  task automatic test_len6();
    apply_reset();
    send_len(32'd6);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    idle(3);
    checks++;
    if (wr_cnt !== 2) begin
      errors++;
      $display("FAIL len6_wr_cnt: got %0d expected 2", wr_cnt);
    end
    checks++;
    if (wr_addr[0] !== 12'd0 || wr_data[0] !== 32'h04030201) begin
      errors++;
      $display("FAIL len6_word0: got addr=%h data=%h expected 000/04030201",
               wr_addr[0], wr_data[0]);
    end
    checks++;
    if (wr_addr[1] !== 12'd1 || wr_data[1] !== 32'h00000605) begin
      errors++;
      $display("FAIL len6_word1: got addr=%h data=%h expected 001/00000605",
               wr_addr[1], wr_data[1]);
    end
    checks++;
    if (start_pcyc !== wr_pcyc[1] + 1 || overlap !== 1'b0) begin
      errors++;
      $display("FAIL len6_start: got start=%0d overlap=%b expected %0d/0",
               start_pcyc, overlap, wr_pcyc[1] + 1);
    end
    checks++;
    if (busy !== 1'b0 || cpu_start !== 1'b1) begin
      errors++;
      $display("FAIL len6_run_state: got busy=%b start=%b expected 0/1", busy, cpu_start);
    end
  endtask

  task automatic test_run_passthrough();
    int p0;
    send_byte(8'h41);
    p0 = last_pcyc;
    send_byte(8'h0A);
    idle(3);
    checks++;
    if (rx_cnt !== 2) begin
      errors++;
      $display("FAIL pass_cnt: got %0d expected 2", rx_cnt);
    end
    checks++;
    if (rxd[0] !== 8'h41 || rxd[1] !== 8'h0A) begin
      errors++;
      $display("FAIL pass_data: got %h %h expected 41 0a", rxd[0], rxd[1]);
    end
    checks++;
    if (rx_pcyc[0] !== p0 || rx_pcyc[1] !== p0 + 1) begin
      errors++;
      $display("FAIL pass_timing: got %0d %0d expected %0d %0d",
               rx_pcyc[0], rx_pcyc[1], p0, p0 + 1);
    end
    checks++;
    if (wr_cnt !== 2) begin
      errors++;
      $display("FAIL pass_no_write: got wr_cnt=%0d expected 2", wr_cnt);
    end
  endtask

  task automatic test_len0();
    apply_reset();
    send_len(32'd0);
    checks++;
    if (cpu_start !== 1'b0) begin
      errors++;
      $display("FAIL len0_start_early: got %b expected 0", cpu_start);
    end
    idle(3);
    checks++;
    if (start_pcyc !== last_pcyc + 1) begin
      errors++;
      $display("FAIL len0_start_time: got %0d expected %0d", start_pcyc, last_pcyc + 1);
    end
    checks++;
    if (wr_cnt !== 0 || busy !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL len0_state: got wr=%0d busy=%b err=%b expected 0/0/0",
               wr_cnt, busy, load_err);
    end
  endtask

  task automatic test_err();
    apply_reset();
    send_len(32'h0000_4001);
    idle(1);
    checks++;
    if (load_err !== 1'b1 || busy !== 1'b0 || cpu_start !== 1'b0) begin
      errors++;
      $display("FAIL err_enter: got err=%b busy=%b start=%b expected 1/0/0",
               load_err, busy, cpu_start);
    end
    for (int i = 0; i < 8; i++) send_byte(8'hC0 + 8'(i));
    idle(3);
    checks++;
    if (wr_cnt !== 0 || rx_cnt !== 0 || cpu_start !== 1'b0 || load_err !== 1'b1) begin
      errors++;
      $display("FAIL err_ignore: got wr=%0d rx=%0d start=%b err=%b expected 0/0/0/1",
               wr_cnt, rx_cnt, cpu_start, load_err);
    end
  endtask

  task automatic test_len_boundary();
    apply_reset();
    send_len(32'h0000_4000);
    idle(2);
    checks++;
    if (load_err !== 1'b0 || busy !== 1'b1 || cpu_start !== 1'b0) begin
      errors++;
      $display("FAIL len_cap_exact: got err=%b busy=%b start=%b expected 0/1/0",
               load_err, busy, cpu_start);
    end
  endtask

  task automatic test_full_168();
    logic [7:0]  pb [0:167];
    logic [31:0] exp_w;
    int          bad;
    pb[0] = 8'h15; pb[1] = 8'h00; pb[2] = 8'h40; pb[3] = 8'h00;
    pb[4] = 8'h84; pb[5] = 8'h0a; pb[6] = 8'h40; pb[7] = 8'h08;
    for (int i = 8; i < 164; i++) pb[i] = 8'((i * 7 + 3) & 255);
    pb[164] = 8'h0E; pb[165] = 8'hC8; pb[166] = 8'hFF; pb[167] = 8'h37;
    apply_reset();
    send_len(32'd168);
    for (int i = 0; i < 168; i++) send_byte(pb[i]);
    idle(3);
    checks++;
    if (wr_cnt !== 42) begin
      errors++;
      $display("FAIL full_wr_cnt: got %0d expected 42", wr_cnt);
    end
    checks++;
    if (wr_data[0] !== 32'h00400015 || wr_data[1] !== 32'h08400A84) begin
      errors++;
      $display("FAIL full_first_words: got %h %h expected 00400015 08400a84",
               wr_data[0], wr_data[1]);
    end
    checks++;
    if (wr_addr[41] !== 12'd41 || wr_data[41] !== 32'h37FFC80E) begin
      errors++;
      $display("FAIL full_last_word: got addr=%0d data=%h expected 41/37ffc80e",
               wr_addr[41], wr_data[41]);
    end
    bad = 0;
    for (int w = 0; w < 42; w++) begin
      exp_w = {pb[4*w+3], pb[4*w+2], pb[4*w+1], pb[4*w]};
      if (wr_data[w] !== exp_w || wr_addr[w] !== 12'(w)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL full_all_words: got %0d bad words expected 0", bad);
    end
    checks++;
    if (start_pcyc !== wr_pcyc[41] + 1 || overlap !== 1'b0 || rx_cnt !== 0) begin
      errors++;
      $display("FAIL full_start: got start=%0d overlap=%b rx=%0d expected %0d/0/0",
               start_pcyc, overlap, rx_cnt, wr_pcyc[41] + 1);
    end
  endtask

  task automatic test_reset_midload();
    apply_reset();
`ifdef LOADER_ACK_EN
    tx_ready = 1'b0;
`endif
    send_len(32'd168);
    for (int i = 0; i < 10; i++) send_byte(8'h50 + 8'(i));
    checks++;
    if (wr_cnt !== 2) begin
      errors++;
      $display("FAIL midload_pre_writes: got %0d expected 2", wr_cnt);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({imem_we, cpu_start, cpu_rx_valid, load_err, busy} !== 5'b0 ||
        imem_addr !== 12'd0 || imem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL midload_reset_outs: got ctrl=%b addr=%h wdata=%h expected 0",
               {imem_we, cpu_start, cpu_rx_valid, load_err, busy}, imem_addr, imem_wdata);
    end
    idle(1);
    clear_mon();
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    send_len(32'd4);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    idle(3);
    checks++;
    if (wr_cnt !== 1 || wr_addr[0] !== 12'd0 || wr_data[0] !== 32'hEFBEADDE) begin
      errors++;
      $display("FAIL midload_reload: got cnt=%0d addr=%h data=%h expected 1/000/efbeadde",
               wr_cnt, wr_addr[0], wr_data[0]);
    end
`ifdef LOADER_ACK_EN
    idle(4);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hAA) begin
      errors++;
      $display("FAIL ack_hold: got valid=%b data=%h expected 1/aa", tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    idle(1);
    tx_ready = 1'b0;
    idle(3);
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_drop: got valid=%b expected 0", tx_valid);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_len6();
    test_run_passthrough();
    test_len0();
    test_err();
    test_len_boundary();
    test_full_168();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Sits between the UART receiver and instruction memory / core start logic.
- Boot protocol: a 4-byte little-endian byte count N, then N program bytes.
- Assembles the program bytes into 32-bit little-endian words and writes them to instruction memory from word address 0.
- Then asserts cpu_start and forwards all later UART bytes to the core as runtime input.

Parameters:
- IMEM_ADDR_W, 12: instruction-memory word-address width; capacity is 2^IMEM_ADDR_W words.
- LEN_W, 32: width of the length field and byte counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  one-cycle strobe: rx_data valid
- imem_we  out  1  instruction-memory write enable
- imem_addr  out  IMEM_ADDR_W  word address
- imem_wdata  out  32  word data
- cpu_start  out  1  level; core released from hold when high
- cpu_rx_data  out  8  runtime byte to core
- cpu_rx_valid  out  1  one-cycle strobe for cpu_rx_data
- load_err  out  1  sticky: declared length exceeds capacity
- busy  out  1  high while in LEN or DATA

Behaviour:
- Reset: every output is 0; state=LEN; byte counter=0; word buffer=0; address=0. Reset asserted mid-load aborts the load and forces the same values; the next boot restarts from length byte 0.
- The block never stalls; rx_valid bytes are always accepted.
- LEN state:
  - Collect 4 bytes; the first byte is the LSB.
  - On the 4th byte: if N=0, go to RUN.
  - If N > 4*2^IMEM_ADDR_W, go to ERR.
  - Otherwise go to DATA; remaining counter = N.
- DATA state:
  - Each byte shifts into the word buffer at lane (byte index mod 4); lane 0 is bits 7:0.
  - On lane 3, or on the last byte of N (remaining=1):
    - Next cycle: imem_we=1 for exactly one cycle, imem_wdata=buffer including that byte, imem_addr=current word address.
    - Unfilled lanes of a final partial word are 0.
    - Address increments after the write; buffer clears.
  - Latency: the rx_valid of the completing byte at cycle t gives imem_we at t+1.
  - After the last byte's write (t+1), go to RUN at t+1; cpu_start rises at t+2, so it is never high in the same cycle as an imem write.
- RUN state:
  - cpu_start=1 and held until reset.
  - Each rx_valid gives cpu_rx_valid=1 one cycle later, with cpu_rx_data=that byte (registered one-stage passthrough).
  - imem_we stays 0.
- ERR state:
  - load_err=1, busy=0, cpu_start=0.
  - All further bytes are ignored; only rst exits.
- cpu_rx_valid is 0 in every state except RUN.
- Back-to-back rx_valid on consecutive cycles must be handled: a write strobe and the next byte capture can occur in the same cycle.
- busy=1 exactly in LEN and DATA.

Optional Feature:
- Macro LOADER_ACK_EN.
- When defined:
  - Extra ports tx_data(8,out), tx_valid(1,out), tx_ready(1,in).
  - On entry to RUN, present byte 0xAA with tx_valid=1 and hold it until tx_ready is sampled high, then drop tx_valid. Exactly one ack per load.
  - ERR presents 0xEE in the same way.
  - RUN passthrough is unaffected by a pending ack.
- When undefined: these ports and the logic are absent; behaviour is otherwise identical.

Test Plan:
- Length 168 (A8 00 00 00), then 168 bytes starting 15 00 40 00 84 0a 40 08 -> 42 writes; addr0=0x00400015, addr1=0x08400A84; last addr41=0x37FFC80E; cpu_start rises one cycle after the addr41 write.
- Length 6, bytes 01..06 -> addr0=0x04030201, addr1=0x00000605; exactly 2 imem_we pulses.
- Length 0 -> no imem_we; cpu_start=1 two cycles after the 4th length byte.
- Length 0x00004001 with IMEM_ADDR_W=12 -> load_err=1, cpu_start stays 0, no writes; later bytes ignored.
- After load, send 0x41 and 0x0A back-to-back -> two cpu_rx_valid pulses one cycle after each, data 0x41 then 0x0A.
- Assert rst after 10 program bytes, reload length 4 with DE AD BE EF -> single write addr0=0xEFBEADDE; with LOADER_ACK_EN, tx_valid holds 0xAA until tx_ready.
